// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic [5:0] count_t;

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter: synchronous clear, enable, terminal-count flag at TERM.
module multdiv_counter
  import multdiv_pkg::*;
#(
  parameter count_t TERM = count_t'(ITER)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  count_t count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;
  end

  assign term = (count == TERM);

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit, fixed latency,
// one operation in flight; sign handling is done on magnitudes around the core.
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [4:0]       ctrl_destReg,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic [4:0]       ctrl_writeRegOut,
  output logic             ctrl_busy
);
  import multdiv_pkg::*;

  localparam int MW = WIDTH + 1;
  localparam int AW = 2 * WIDTH;
  localparam logic [AW-1:0] NEG_LIMIT = AW'(INT_MIN);
  localparam logic [AW-1:0] POS_LIMIT = AW'(INT_MIN) - 1'b1;

  // Magnitude needs one extra bit so that INT_MIN maps to +2^(WIDTH-1).
  function automatic logic [MW-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic signed [MW-1:0] ext;
    ext = {v[WIDTH-1], v};
    return ext[MW-1] ? -ext : ext;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [AW-1:0] m, input logic neg);
    logic [AW-1:0] s;
    s = neg ? (~m + 1'b1) : m;
    return s[WIDTH-1:0];
  endfunction

  function automatic logic mul_overflow(input logic [AW-1:0] m, input logic neg);
    return neg ? (m > NEG_LIMIT) : (m > POS_LIMIT);
  endfunction

  function automatic logic div_overflow(input logic [WIDTH-1:0] q, input logic neg,
                                        input logic div0);
    return div0 || (!neg && (q == INT_MIN));
  endfunction

  state_t          state, next_state;
  logic            term;
  logic            accept, iterate, load;
  logic [AW-1:0]   opa, acc;
  logic [MW-1:0]   opb;
  logic            neg_q;
  logic [4:0]      dest_q;
  logic [MW-1:0]   rem_sh;
  logic            q_bit;
  logic            div0;

  multdiv_counter #(.TERM(count_t'(ITER))) u_counter (
    .clk  (clock),
    .rst  (ctrl_reset),
    .clr  (accept),
    .en   (iterate),
    .term (term)
  );

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) state <= IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    iterate    = 1'b0;
    load       = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        next_state = IDLE;
        if (ctrl_MULT) begin
          accept     = 1'b1;
          next_state = MUL;
        end else if (ctrl_DIV) begin
          accept     = 1'b1;
          next_state = DIV;
        end
      end
      MUL, DIV: begin
        if (term) begin
          load       = 1'b1;
          next_state = DONE;
        end else begin
          iterate = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign ctrl_busy = iterate;

  // Divide step: remainder lives in acc, dividend/quotient shifts through opa.
  assign rem_sh = {acc[WIDTH-1:0], opa[WIDTH-1]};
  assign q_bit  = (rem_sh >= opb);
  assign div0   = (opb == '0);

  always_ff @(posedge clock) begin
    if (accept) begin
      neg_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dest_q <= ctrl_destReg;
      opa    <= AW'(magnitude(data_operandA));
      opb    <= magnitude(data_operandB);
      acc    <= '0;
    end else if (iterate) begin
      if (state == MUL) begin
        if (opb[0]) acc <= acc + opa;
        opa <= opa << 1;
        opb <= opb >> 1;
      end else begin
        opa <= AW'({opa[WIDTH-2:0], q_bit});
        acc <= q_bit ? AW'(rem_sh - opb) : AW'(rem_sh);
      end
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      data_result      <= '0;
      data_exception   <= 1'b0;
      data_resultRDY   <= 1'b0;
      ctrl_writeRegOut <= '0;
    end else begin
      data_resultRDY <= load;
      if (load) begin
        ctrl_writeRegOut <= dest_q;
        if (state == MUL) begin
          data_result    <= apply_sign(acc, neg_q);
          data_exception <= mul_overflow(acc, neg_q);
        end else begin
          data_result    <= div0 ? '0 : apply_sign(AW'(opa[WIDTH-1:0]), neg_q);
          data_exception <= div_overflow(opa[WIDTH-1:0], neg_q, div0);
        end
      end
    end
  end

endmodule
